i2s_dac_tx: RTL and testbench

Stereo I2S transmitter for the WM8731 codec DAC path, clocked from the system clock with the codec as bit-clock and LR-clock master. Upstream sample generators (tone synthesis, loopback, playback) push 16-bit left/right pairs through a valid/ready port into a small FIFO. The block serialises one pair per LR frame onto AUD_DACDAT in standard I2S format and reports underruns and frame boundaries back upstream.

---
 rtl/i2s_dac_tx.sv | 184 ++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter for the WM8731 DAC path: a small pair FIFO feeding a
// bit serialiser that runs on synchronised codec BCLK/LRCK edges.
module i2s_dac_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_left,
  input  logic [WIDTH-1:0]       in_right,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT,
  output logic                   frame_tick,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_PAD   = 2'd3;

  logic bclk_meta_q, bclk_s_q, bclk_prev_q;
  logic lrck_meta_q, lrck_s_q;
  logic lr_cur_q, lr_prev_q;

  logic [PW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]    fill_q, fill_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] hold_l_q, hold_r_q;
  logic             frame_tick_q, underrun_q;

  logic [1:0]       state_q, state_d, state_sel_c;
  logic [WIDTH-1:0] shift_q, shift_d, word_c;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             dat_q, dat_d;

  logic bclk_rise_c, bclk_fall_c, chan_start_c, pop_slot_c;
  logic push_c, pop_c, empty_c;
  logic [PW-1:0] head_c;

  // Two-stage synchronisers; LRCK idles high so reset looks like "right channel".
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      bclk_meta_q <= 1'b0;
      bclk_s_q    <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b1;
      lrck_s_q    <= 1'b1;
    end else begin
      bclk_meta_q <= AUD_BCLK;
      bclk_s_q    <= bclk_meta_q;
      bclk_prev_q <= bclk_s_q;
      lrck_meta_q <= AUD_DACLRCK;
      lrck_s_q    <= lrck_meta_q;
    end
  end

  assign bclk_rise_c  = bclk_s_q & ~bclk_prev_q;
  assign bclk_fall_c  = ~bclk_s_q & bclk_prev_q;
  assign chan_start_c = lr_cur_q != lr_prev_q;
  assign pop_slot_c   = bclk_rise_c && !lrck_s_q && lr_cur_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lr_cur_q  <= 1'b1;
      lr_prev_q <= 1'b1;
    end else if (bclk_rise_c) begin
      lr_cur_q  <= lrck_s_q;
      lr_prev_q <= lr_cur_q;
    end
  end

  assign empty_c = fill_q == '0;
  assign push_c  = in_valid && in_ready_q;
  assign pop_c   = pop_slot_c && !empty_c;
  assign head_c  = mem_q[rd_ptr_q];

  always_comb begin
    fill_d = fill_q;
    if (push_c && !pop_c) begin
      fill_d = fill_q + FW'(1);
    end else if (!push_c && pop_c) begin
      fill_d = fill_q - FW'(1);
    end
    in_ready_d = fill_d < FW'(DEPTH);
  end

  always_ff @(posedge CLOCK) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  // A pop slot on an empty FIFO (even with a same-cycle push) loads silence.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      in_ready_q   <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      frame_tick_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fill_q       <= fill_d;
      in_ready_q   <= in_ready_d;
      frame_tick_q <= pop_slot_c;
      underrun_q   <= pop_slot_c && empty_c;
      if (pop_slot_c) begin
        hold_l_q <= pop_c ? head_c[PW-1:WIDTH] : '0;
        hold_r_q <= pop_c ? head_c[WIDTH-1:0] : '0;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      dat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dat_q    <= dat_d;
    end
  end

  // A pending channel start overrides whatever word is in flight.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    dat_d       = dat_q;
    state_sel_c = chan_start_c ? ST_LOAD : state_q;
    word_c      = lr_cur_q ? hold_r_q : hold_l_q;
    if (bclk_fall_c) begin
      case (state_sel_c)
        ST_LOAD: begin
          shift_d  = word_c;
          dat_d    = word_c[WIDTH-1];
          bitcnt_d = CW'(WIDTH - 1);
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bitcnt_q == '0) begin
            dat_d   = 1'b0;
            state_d = ST_PAD;
          end else begin
            shift_d  = WIDTH'(shift_q << 1);
            dat_d    = shift_q[WIDTH-2];
            bitcnt_d = bitcnt_q - CW'(1);
          end
        end
        default: dat_d = 1'b0;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign fill       = fill_q;
  assign frame_tick = frame_tick_q;
  assign underrun   = underrun_q;
  assign AUD_DACDAT = dat_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed/randomised bench for i2s_dac_tx: a codec-side model predicts every
// captured DAC bit plus frame_tick/underrun counts and FIFO occupancy.
module tb_i2s_dac_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIV   = 8;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_left = '0;
  logic [WIDTH-1:0] in_right = '0;
  logic             AUD_BCLK = 1'b0;
  logic             AUD_DACLRCK = 1'b1;
  logic             AUD_DACDAT;
  logic             frame_tick;
  logic             underrun;
  logic [2:0]       fill;

  i2s_dac_tx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .frame_tick(frame_tick), .underrun(underrun), .fill(fill)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codec clock generator: BCLK = CLOCK/16, LRCK toggles on BCLK falls.
  bit gen_en = 1'b0;
  int half_bits = 32;
  int div_cnt = 0;
  int bit_pos = 0;
  always @(negedge CLOCK) begin
    if (gen_en) begin
      div_cnt++;
      if (div_cnt == DIV) begin
        div_cnt = 0;
        if (AUD_BCLK) begin
          AUD_BCLK = 1'b0;
          bit_pos++;
          if (bit_pos >= half_bits) begin
            bit_pos = 0;
            AUD_DACLRCK = ~AUD_DACLRCK;
          end
        end else begin
          AUD_BCLK = 1'b1;
        end
      end
    end
  end

  // Reference model: each word occupies the WIDTH capture rises after its
  // channel start; everything else is zero.
  logic [2*WIDTH-1:0] q[$];
  logic [WIDTH-1:0]   m_hold_l = '0;
  logic [WIDTH-1:0]   m_hold_r = '0;
  logic [WIDTH-1:0]   m_word = '0;
  logic               m_lr = 1'b1;
  int                 m_pos = 1000;
  int                 exp_ticks = 0;
  int                 exp_unders = 0;
  int                 left_starts = 0;
  bit                 skip_boundary = 1'b0;

  always @(posedge AUD_BCLK or posedge RESET) begin
    logic [WIDTH-1:0] sh;
    logic             exp_bit;
    logic             start;
    if (RESET) begin
      q.delete();
      m_hold_l = '0;
      m_hold_r = '0;
      m_word   = '0;
      m_pos    = 1000;
      m_lr     = 1'b1;
    end else begin
      m_pos++;
      sh      = m_word << (m_pos - 1);
      exp_bit = (m_pos >= 1 && m_pos <= WIDTH) ? sh[WIDTH-1] : 1'b0;
      start   = AUD_DACLRCK != m_lr;
      // In short frames the bit under the LRCK edge is left unchecked.
      if (!(start && skip_boundary)) chk("dacdat_bit", 32'(AUD_DACDAT), 32'(exp_bit));
      if (start) begin
        if (!AUD_DACLRCK) begin
          left_starts++;
          exp_ticks++;
          if (q.size() == 0) begin
            exp_unders++;
            m_hold_l = '0;
            m_hold_r = '0;
          end else begin
            {m_hold_l, m_hold_r} = q.pop_front();
          end
          m_word = m_hold_l;
        end else begin
          m_word = m_hold_r;
        end
        m_pos = 0;
        m_lr  = AUD_DACLRCK;
      end
    end
  end

  int ticks_seen = 0;
  int unders_seen = 0;
  always @(posedge CLOCK) begin
    if (frame_tick === 1'b1) ticks_seen++;
    if (underrun === 1'b1) unders_seen++;
  end

  task automatic push_pair(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    int guard;
    @(negedge CLOCK);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 4000) begin
      @(negedge CLOCK);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: observed in_ready %0b expected 1", in_ready);
    end else begin
      @(posedge CLOCK);
      q.push_back({l, r});
    end
  endtask

  task automatic wait_left_start(input int n);
    int base;
    int guard;
    base  = left_starts;
    guard = 0;
    while (left_starts < base + n && guard < 4000 * n) begin
      @(negedge CLOCK);
      guard++;
    end
    if (left_starts < base + n) begin
      checks++;
      errors++;
      $error("FAIL left_start_timeout: observed %0d expected %0d", left_starts - base, n);
    end
    repeat (6) @(negedge CLOCK);
  endtask

  initial begin
    int guard;
    logic [WIDTH-1:0] l5, r5;

    // Reset values
    repeat (3) @(negedge CLOCK);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_dacdat", 32'(AUD_DACDAT), 0);
    chk("rst_frame_tick", 32'(frame_tick), 0);
    chk("rst_underrun", 32'(underrun), 0);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("ready_after_rst", 32'(in_ready), 1);
    gen_en = 1'b1;

    // Idle frames: silence, one underrun per frame
    wait_left_start(3);
    chk("idle_ticks", 32'(ticks_seen), 32'(exp_ticks));
    chk("idle_underruns", 32'(unders_seen), 32'(exp_unders));
    chk("idle_fill", 32'(fill), 0);
    chk("idle_in_ready", 32'(in_ready), 1);

    // Single known pair
    push_pair(16'hA5C3, 16'h3C5A);
    @(negedge CLOCK);
    in_valid = 1'b0;
    chk("one_pair_fill", 32'(fill), 1);
    wait_left_start(3);
    chk("one_pair_underruns", 32'(unders_seen), 32'(exp_unders));

    // Fill the FIFO, hold off a fifth pair until the first pop
    for (int i = 0; i < 4; i++) push_pair(WIDTH'($urandom), WIDTH'($urandom));
    @(negedge CLOCK);
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_fill", 32'(fill), 4);
    l5       = WIDTH'($urandom);
    r5       = WIDTH'($urandom);
    in_left  = l5;
    in_right = r5;
    in_valid = 1'b1;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 3000) begin
      @(negedge CLOCK);
      guard++;
    end
    chk("held_ready_rise", 32'(in_ready), 1);
    chk("ready_with_pop_tick", 32'(frame_tick), 1);
    chk("fill_after_pop", 32'(fill), 3);
    @(posedge CLOCK);
    q.push_back({l5, r5});
    @(negedge CLOCK);
    in_valid = 1'b0;
    chk("refull_fill", 32'(fill), 4);
    chk("refull_in_ready", 32'(in_ready), 0);
    wait_left_start(6);
    chk("drain_fill", 32'(fill), 0);

    // Push lands on the exact cycle of an empty pop slot
    @(negedge AUD_DACLRCK);
    @(posedge AUD_BCLK);
    @(posedge CLOCK);
    @(posedge CLOCK);
    @(negedge CLOCK);
    in_left  = WIDTH'($urandom);
    in_right = WIDTH'($urandom);
    in_valid = 1'b1;
    @(posedge CLOCK);
    q.push_back({in_left, in_right});
    @(negedge CLOCK);
    in_valid = 1'b0;
    chk("race_underrun", 32'(underrun), 1);
    chk("race_frame_tick", 32'(frame_tick), 1);
    chk("race_fill", 32'(fill), 1);
    wait_left_start(2);
    chk("race_fill_drained", 32'(fill), 0);

    // Short frames: exactly WIDTH BCLKs per channel
    half_bits     = 16;
    skip_boundary = 1'b1;
    wait_left_start(2);
    push_pair(16'h8001, WIDTH'($urandom));
    @(negedge CLOCK);
    in_valid = 1'b0;
    wait_left_start(3);
    half_bits = 32;
    wait_left_start(2);
    skip_boundary = 1'b0;

    // Reset in the middle of a left word with two pairs still queued
    for (int i = 0; i < 3; i++) push_pair(WIDTH'($urandom), WIDTH'($urandom));
    @(negedge CLOCK);
    in_valid = 1'b0;
    wait_left_start(1);
    chk("pre_rst_fill", 32'(fill), 2);
    repeat (4) @(negedge AUD_BCLK);
    @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    chk("midrst_fill", 32'(fill), 0);
    chk("midrst_dacdat", 32'(AUD_DACDAT), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    repeat (5) @(negedge CLOCK);
    RESET = 1'b0;
    wait_left_start(1);
    chk("post_rst_underruns", 32'(unders_seen), 32'(exp_unders));
    chk("post_rst_underrun_pulse", 32'(underrun), 0);
    chk("post_rst_fill", 32'(fill), 0);
    wait_left_start(2);

    chk("total_ticks", 32'(ticks_seen), 32'(exp_ticks));
    chk("total_underruns", 32'(unders_seen), 32'(exp_unders));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
